xadc_scan_dmm: RTL and testbench

- Parametrised successor to the single-channel XADC voltmeter top.
- Sequences DRP reads over NUM_CH XADC channels once per end-of-conversion, averages each channel over 2^AVG_LOG2 samples, and holds the results in a register file.
- Drives a 16-LED thermometer bar and a sequential binary-to-BCD converter for the channel picked by sel, feeding the existing DigitToSeg driver.

---
 rtl/xadc_scan_dmm.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_xadc_scan_dmm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_scan_dmm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : xadc_scan_dmm                                                   |
// | Purpose  : Multi-channel XADC voltmeter. Reads NUM_CH channels over the    |
// |            DRP once per end-of-conversion, averages 2^AVG_LOG2 samples per |
// |            channel, and presents the selected channel as a 16-LED          |
// |            thermometer bar and as BCD digits (sequential double-dabble).   |
// | Ports    : CLK100MHZ, reset_in (async, active-high)                        |
// |            eoc_in, drdy_in, do_in[15:0]  <- XADC                           |
// |            daddr_out[6:0], den_out       -> XADC DRP                       |
// |            sel[2:0]                      display channel select            |
// |            LED[15:0], digits[4*NUM_DIGITS-1:0], digits_valid, drdy_err     |
// |            over_thresh[NUM_CH-1:0]       only with SCAN_THRESH_EN          |
// | Options  : `define SCAN_THRESH_EN adds THRESH_CODE/HYST and over_thresh.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module xadc_scan_dmm #(
    parameter int                   NUM_CH        = 4,
    parameter logic [7*NUM_CH-1:0]  CH_ADDRS      = {7'h1b, 7'h1a, 7'h13, 7'h12},
    parameter int                   AVG_LOG2      = 2,
    parameter int                   SCALE         = 250000,
    parameter int                   CLAMP_CODE    = 4093,
    parameter int                   NUM_DIGITS    = 7,
    parameter int                   UPDATE_CYCLES = 10000000,
    parameter int                   DRDY_TIMEOUT  = 255
`ifdef SCAN_THRESH_EN
    ,
    parameter logic [11:0]          THRESH_CODE   = 12'hC00,
    parameter logic [11:0]          HYST          = 12'h040
`endif
) (
    input  logic                      CLK100MHZ,
    input  logic                      reset_in,
    input  logic                      eoc_in,
    input  logic                      drdy_in,
    input  logic [15:0]               do_in,
    output logic [6:0]                daddr_out,
    output logic                      den_out,
    input  logic [2:0]                sel,
    output logic [15:0]               LED,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic                      digits_valid,
    output logic                      drdy_err
`ifdef SCAN_THRESH_EN
    ,
    output logic [NUM_CH-1:0]         over_thresh
`endif
);

    localparam int c_CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_ACCW  = 12 + AVG_LOG2;
    localparam int c_CNTW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_TMOW  = $clog2(DRDY_TIMEOUT + 1);
    localparam int c_UPDW  = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam int c_BCDW  = 4 * NUM_DIGITS;

    localparam logic [c_CHW-1:0]  c_CH_LAST   = c_CHW'(NUM_CH - 1);
    localparam logic [c_CNTW-1:0] c_CNT_LAST  = c_CNTW'((1 << AVG_LOG2) - 1);
    localparam logic [c_TMOW-1:0] c_TMO_LAST  = c_TMOW'(DRDY_TIMEOUT - 1);
    localparam logic [c_UPDW-1:0] c_UPD_LAST  = c_UPDW'(UPDATE_CYCLES - 1);
    localparam logic [12:0]       c_CLAMP     = 13'(CLAMP_CODE);
    localparam logic [29:0]       c_CLAMP_VAL = 30'(10 ** (NUM_DIGITS - 1));
    localparam logic [4:0]        c_SHIFT_LAST = 5'd29;

    // Scan FSM encoding
    localparam logic [1:0] c_SCAN_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN_REQ  = 2'd1;
    localparam logic [1:0] c_SCAN_WAIT = 2'd2;

    // Display FSM encoding
    localparam logic [1:0] c_DISP_IDLE  = 2'd0;
    localparam logic [1:0] c_DISP_LOAD  = 2'd1;
    localparam logic [1:0] c_DISP_SHIFT = 2'd2;
    localparam logic [1:0] c_DISP_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // DRP scan sequencer
    // ------------------------------------------------------------------
    logic [1:0]        r_scan_st, w_scan_nxt;
    logic [c_CHW-1:0]  r_ch, w_ch_nxt;
    logic              w_enter_req, w_sample, w_timeout;
    logic [c_TMOW-1:0] r_tmo;
    logic [6:0]        r_daddr, w_addr_nxt;
    logic              r_drdy_err;
    logic [11:0]       w_code;
    logic              w_unused_bits;

    assign w_code        = do_in[15:4];
    assign w_unused_bits = ^do_in[3:0];

    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) begin
            r_scan_st <= c_SCAN_IDLE;
            r_ch      <= '0;
        end else begin
            r_scan_st <= w_scan_nxt;
            r_ch      <= w_ch_nxt;
        end
    end

    always_comb begin
        w_scan_nxt  = r_scan_st;
        w_ch_nxt    = r_ch;
        w_enter_req = 1'b0;
        w_sample    = 1'b0;
        w_timeout   = 1'b0;
        case (r_scan_st)
            c_SCAN_IDLE: begin
                if (eoc_in) begin
                    w_ch_nxt    = '0;
                    w_enter_req = 1'b1;
                    w_scan_nxt  = c_SCAN_REQ;
                end
            end
            c_SCAN_REQ: w_scan_nxt = c_SCAN_WAIT;
            c_SCAN_WAIT: begin
                // A response on the last allowed cycle still wins over the timeout.
                if (drdy_in) begin
                    w_sample = 1'b1;
                    if (r_ch == c_CH_LAST) begin
                        w_scan_nxt = c_SCAN_IDLE;
                    end else begin
                        w_ch_nxt    = r_ch + 1'b1;
                        w_enter_req = 1'b1;
                        w_scan_nxt  = c_SCAN_REQ;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_timeout  = 1'b1;
                    w_scan_nxt = c_SCAN_IDLE;
                end
            end
            default: w_scan_nxt = c_SCAN_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt = CH_ADDRS[6:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch_nxt == c_CHW'(i)) w_addr_nxt = CH_ADDRS[7*i +: 7];
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) begin
            r_daddr    <= '0;
            r_tmo      <= '0;
            r_drdy_err <= 1'b0;
        end else begin
            // Address is captured on entry to REQ and held across WAIT/IDLE.
            if (w_enter_req) r_daddr <= w_addr_nxt;
            r_tmo <= '0;
            if (r_scan_st == c_SCAN_WAIT && !drdy_in) r_tmo <= r_tmo + 1'b1;
            if (w_timeout) r_drdy_err <= 1'b1;
        end
    end

    assign den_out   = (r_scan_st == c_SCAN_REQ);
    assign daddr_out = r_daddr;
    assign drdy_err  = r_drdy_err;

    // ------------------------------------------------------------------
    // Per-channel averaging and result register file
    // ------------------------------------------------------------------
    logic [12*NUM_CH-1:0] w_results;

`ifdef SCAN_THRESH_EN
    localparam logic [11:0] c_THRESH_LO = THRESH_CODE - HYST;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [c_ACCW-1:0] r_acc;
        logic [c_CNTW-1:0] r_cnt;
        logic [11:0]       r_res;
        logic [c_ACCW-1:0] w_sum;
        logic [11:0]       w_avg;
        logic              w_hit;
        logic              w_last;

        assign w_hit  = w_sample && (r_ch == c_CHW'(gi));
        assign w_last = (r_cnt == c_CNT_LAST);
        assign w_sum  = r_acc + c_ACCW'(w_code);
        assign w_avg  = w_sum[c_ACCW-1 -: 12];

        always_ff @(posedge CLK100MHZ or posedge reset_in) begin
            if (reset_in) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_res <= '0;
            end else if (w_hit) begin
                if (w_last) begin
                    r_res <= w_avg;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_results[12*gi +: 12] = r_res;

`ifdef SCAN_THRESH_EN
        logic r_over;
        // Hysteresis band: values between THRESH-HYST and THRESH keep the old state.
        always_ff @(posedge CLK100MHZ or posedge reset_in) begin
            if (reset_in) begin
                r_over <= 1'b0;
            end else if (w_hit && w_last) begin
                if (w_avg > THRESH_CODE)      r_over <= 1'b1;
                else if (w_avg < c_THRESH_LO) r_over <= 1'b0;
            end
        end
        assign over_thresh[gi] = r_over;
`endif
    end

    // Out-of-range select values fall back to channel 0.
    logic [11:0] w_sel_res;
    always_comb begin
        w_sel_res = w_results[11:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == 3'(i)) w_sel_res = w_results[12*i +: 12];
        end
    end

    // ------------------------------------------------------------------
    // LED thermometer: n lit segments above the always-on LED0
    // ------------------------------------------------------------------
    logic [15:0] r_led;
    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) r_led <= 16'h0001;
        else          r_led <= ~(16'hFFFE << w_sel_res[11:8]);
    end
    assign LED = r_led;

    // ------------------------------------------------------------------
    // Display refresh and sequential binary-to-BCD
    // ------------------------------------------------------------------
    logic [c_UPDW-1:0] r_upd_cnt;
    logic              w_tick;
    logic [1:0]        r_disp_st, w_disp_nxt;
    logic [11:0]       r_disp_code;
    logic [29:0]       r_bin;
    logic [c_BCDW-1:0] r_bcd, w_bcd_adj, r_digits;
    logic [4:0]        r_shift_cnt;
    logic              r_digits_valid;
    logic [41:0]       w_prod;
    logic [29:0]       w_scaled;
    logic              w_clamp;

    assign w_tick   = (r_upd_cnt == c_UPD_LAST);
    assign w_prod   = 42'(r_disp_code) * 42'(SCALE);
    assign w_scaled = 30'(w_prod >> 10);
    assign w_clamp  = ({1'b0, r_disp_code} >= c_CLAMP);

    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) begin
            r_upd_cnt <= '0;
            r_disp_st <= c_DISP_IDLE;
        end else begin
            r_upd_cnt <= w_tick ? '0 : r_upd_cnt + 1'b1;
            r_disp_st <= w_disp_nxt;
        end
    end

    // Ticks outside IDLE are dropped; the conversion in flight finishes first.
    always_comb begin
        w_disp_nxt = r_disp_st;
        case (r_disp_st)
            c_DISP_IDLE:  if (w_tick) w_disp_nxt = c_DISP_LOAD;
            c_DISP_LOAD:  w_disp_nxt = c_DISP_SHIFT;
            c_DISP_SHIFT: if (r_shift_cnt == c_SHIFT_LAST) w_disp_nxt = c_DISP_DONE;
            c_DISP_DONE:  w_disp_nxt = c_DISP_IDLE;
            default:      w_disp_nxt = c_DISP_IDLE;
        endcase
    end

    // Add-3 correction applied to every digit before each shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset_in) begin
        if (reset_in) begin
            r_disp_code    <= '0;
            r_bin          <= '0;
            r_bcd          <= '0;
            r_shift_cnt    <= '0;
            r_digits       <= '0;
            r_digits_valid <= 1'b0;
        end else begin
            r_digits_valid <= 1'b0;
            case (r_disp_st)
                c_DISP_IDLE: if (w_tick) r_disp_code <= w_sel_res;
                c_DISP_LOAD: begin
                    r_bin       <= w_clamp ? c_CLAMP_VAL : w_scaled;
                    r_bcd       <= '0;
                    r_shift_cnt <= '0;
                end
                c_DISP_SHIFT: begin
                    r_bcd       <= (w_bcd_adj << 1) | c_BCDW'(r_bin[29]);
                    r_bin       <= r_bin << 1;
                    r_shift_cnt <= r_shift_cnt + 1'b1;
                end
                c_DISP_DONE: begin
                    r_digits       <= r_bcd;
                    r_digits_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign digits       = r_digits;
    assign digits_valid = r_digits_valid;

endmodule
`default_nettype wire

// File: tb/tb_xadc_scan_dmm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_xadc_scan_dmm                                                |
// | Purpose  : Directed self-checking bench for xadc_scan_dmm. Acts as the     |
// |            XADC DRP responder, keeps a small averaging/display model and   |
// |            scoreboards DRP addresses and displayed digits.                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_xadc_scan_dmm;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        eoc_in;
    logic        drdy_in;
    logic [15:0] do_in;
    logic [2:0]  sel;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic [15:0] LED;
    logic [27:0] digits;
    logic        digits_valid;
    logic        drdy_err;
`ifdef SCAN_THRESH_EN
    logic [3:0]  over_thresh;
`endif

    always #5 clk = ~clk;

    xadc_scan_dmm #(
        .UPDATE_CYCLES(100)
    ) u_dut (
        .CLK100MHZ    (clk),
        .reset_in     (reset_in),
        .eoc_in       (eoc_in),
        .drdy_in      (drdy_in),
        .do_in        (do_in),
        .daddr_out    (daddr_out),
        .den_out      (den_out),
        .sel          (sel),
        .LED          (LED),
        .digits       (digits),
        .digits_valid (digits_valid),
        .drdy_err     (drdy_err)
`ifdef SCAN_THRESH_EN
        ,
        .over_thresh  (over_thresh)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc;

    logic [6:0]  exp_addr_q [$];
    logic [27:0] exp_dig_q  [$];
    int m_acc [4];
    int m_n   [4];
    int m_res [4];

    // Rising edges since reset release; display ticks land on multiples of 100.
    always @(posedge clk or posedge reset_in) begin
        if (reset_in) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ch_addr(input int i);
        case (i)
            0:       return 7'h12;
            1:       return 7'h13;
            2:       return 7'h1a;
            default: return 7'h1b;
        endcase
    endfunction

    function automatic logic [27:0] model_digits(input int code);
        longint v;
        logic [27:0] d;
        if (code >= 4093) v = 1000000;
        else              v = (longint'(code) * 250000) >> 10;
        d = '0;
        for (int i = 0; i < 7; i++) begin
            d[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return d;
    endfunction

    function automatic logic [15:0] model_led(input int res);
        int n;
        n = (res >> 8) & 15;
        return 16'((32'd1 << (n + 1)) - 1);
    endfunction

    function automatic int sel_res(input logic [2:0] s);
        return (s < 3'd4) ? m_res[s] : m_res[0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_acc[i] = 0; m_n[i] = 0; m_res[i] = 0;
        end
    endtask

    // One full scan: pulse eoc, answer each den with a code one cycle later.
    task automatic do_scan(input int c0, input int c1, input int c2, input int c3);
        int codes [4];
        bit seen;
        codes = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(ch_addr(i));
        @(negedge clk); eoc_in = 1'b1;
        @(negedge clk); eoc_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (den_out) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            check("den_seen", 32'(seen), 32'd1);
            check("daddr", 32'(daddr_out), 32'(exp_addr_q.pop_front()));
            @(negedge clk);
            check("den_pulse", 32'(den_out), 32'd0);
            drdy_in = 1'b1;
            do_in   = {12'(codes[i]), 4'hA};
            m_acc[i] += codes[i];
            m_n[i]++;
            if (m_n[i] == 4) begin
                m_res[i] = m_acc[i] >> 2;
                m_acc[i] = 0;
                m_n[i]   = 0;
            end
            @(negedge clk);
            drdy_in = 1'b0;
            do_in   = 16'h0000;
        end
    endtask

    task automatic wait_display(input string tag);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (digits_valid) begin seen = 1'b1; break; end
        end
        check("valid_seen", 32'(seen), 32'd1);
        check("valid_phase", 32'(cyc % 100), 32'd32);
        check(tag, 32'(digits), 32'(exp_dig_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;

        reset_in = 1'b1; eoc_in = 1'b0; drdy_in = 1'b0; do_in = 16'h0; sel = 3'd0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_led", 32'(LED), 32'h0001);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_den", 32'(den_out), 32'd0);
        check("rst_daddr", 32'(daddr_out), 32'd0);
        check("rst_valid", 32'(digits_valid), 32'd0);
        check("rst_err", 32'(drdy_err), 32'd0);
        reset_in = 1'b0;

        // Three of four samples: nothing averaged yet.
        do_scan(100, 12'h800, 4092, 4094);
        do_scan(200, 12'h800, 4092, 4094);
        do_scan(300, 12'h800, 4092, 4094);
        exp_dig_q.push_back(model_digits(sel_res(sel)));
        wait_display("dig_before_avg");

        // Fourth sample completes the average of channel 0 (250).
        do_scan(400, 12'h800, 4092, 4094);
        exp_dig_q.push_back(model_digits(sel_res(sel)));
        wait_display("dig_avg_ch0");

        sel = 3'd1;
        @(negedge clk);
        check("led_ch1", 32'(LED), 32'(model_led(sel_res(sel))));
        exp_dig_q.push_back(model_digits(sel_res(sel)));
        wait_display("dig_ch1");

        sel = 3'd3;
        @(negedge clk);
        check("led_ch3", 32'(LED), 32'(model_led(sel_res(sel))));
        exp_dig_q.push_back(model_digits(sel_res(sel)));
        wait_display("dig_clamp");

        sel = 3'd2;
        @(negedge clk);
        check("led_ch2", 32'(LED), 32'(model_led(sel_res(sel))));
        exp_dig_q.push_back(model_digits(sel_res(sel)));
        wait_display("dig_below_clamp");

        sel = 3'd5;
        @(negedge clk);
        check("led_sel_oob", 32'(LED), 32'(model_led(sel_res(sel))));

        // DRDY never arrives: timeout after 255 WAIT cycles.
        @(negedge clk); eoc_in = 1'b1;
        @(negedge clk); eoc_in = 1'b0;
        check("tmo_den", 32'(den_out), 32'd1);
        check("tmo_addr", 32'(daddr_out), 32'h12);
        k = 0;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (drdy_err) begin k = t; break; end
        end
        check("tmo_cycles", 32'(k), 32'd256);
        do_scan(10, 20, 30, 40);
        check("err_sticky", 32'(drdy_err), 32'd1);

        // Reset in the middle of a WAIT.
        sel = 3'd2;
        @(negedge clk); eoc_in = 1'b1;
        @(negedge clk); eoc_in = 1'b0;
        check("mid_den", 32'(den_out), 32'd1);
        @(negedge clk);
        reset_in = 1'b1;
        #1;
        check("mid_rst_den", 32'(den_out), 32'd0);
        check("mid_rst_led", 32'(LED), 32'h0001);
        check("mid_rst_digits", 32'(digits), 32'h0);
        check("mid_rst_err", 32'(drdy_err), 32'd0);
        @(negedge clk);
        check("mid_rst_den2", 32'(den_out), 32'd0);
        reset_in = 1'b0;
        model_clear();
        do_scan(0, 0, 12'hC01, 0);
        sel = 3'd0;
        exp_dig_q.push_back(model_digits(sel_res(sel)));
        wait_display("dig_after_reset");

`ifdef SCAN_THRESH_EN
        for (int s = 0; s < 3; s++) do_scan(0, 0, 12'hC01, 0);
        check("thr_set", 32'(over_thresh[2]), 32'd1);
        for (int s = 0; s < 4; s++) do_scan(0, 0, 12'hBF0, 0);
        check("thr_hold", 32'(over_thresh[2]), 32'd1);
        for (int s = 0; s < 4; s++) do_scan(0, 0, 12'hBBF, 0);
        check("thr_clear", 32'(over_thresh[2]), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
